// File: rtl/mcu_arb_pkg.sv
// mcu_arb_pkg: state encoding and default timing constants shared by mcu_spi_arbiter
package mcu_arb_pkg;
  typedef enum logic [2:0] {ST_INT, ST_SW_EXT, ST_GAP_EXT, ST_EXT, ST_GAP_INT} arb_state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int DET_CYCLES_D = 16;
  localparam int GUARD_CYCLES_D = 4;
  localparam logic [23:0] EXT_TIMEOUT_D = 24'hFFFFFF;
endpackage

// File: rtl/mcu_spi_arbiter_if.sv
// mcu_spi_arbiter_if: board-pin masters and core-side SPI port of the arbiter
interface mcu_spi_arbiter_if;
  logic int_sclk, int_csn, int_mosi;
  logic ext_sclk, ext_csn, ext_mosi;
  logic mcu_sclk, mcu_csn, mcu_mosi;
  logic sel_ext, switching;
  logic [7:0] blocked_cnt;
  modport slave (
    input int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi,
    output mcu_sclk, mcu_csn, mcu_mosi, sel_ext, switching, blocked_cnt
  );
  modport master (
    output int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi,
    input mcu_sclk, mcu_csn, mcu_mosi, sel_ext, switching, blocked_cnt
  );
endinterface

// File: rtl/spi_sync.sv
// spi_sync: N-stage synchronizer, asynchronously reset to 1 (idle chip select)
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '1;
    else sr <= (sr << 1) | N'(d);
  assign q = sr[N-1];
endmodule

// File: rtl/mcu_spi_arbiter.sv
// mcu_spi_arbiter: frame-safe sharing of the MCU SPI port between BL616 and M0S Dock
// define MCU_ARB_TIMEOUT_EN to hand the port back to BL616 after a long external idle
module mcu_spi_arbiter
  import mcu_arb_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DET_CYCLES = DET_CYCLES_D,
  parameter int GUARD_CYCLES = GUARD_CYCLES_D
`ifdef MCU_ARB_TIMEOUT_EN
  , parameter logic [23:0] EXT_TIMEOUT = EXT_TIMEOUT_D
`endif
) (
  input logic clk32,
  input logic por,
  mcu_spi_arbiter_if.slave bus
);
  localparam int DW = $clog2(DET_CYCLES + 1);
  localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
  arb_state_t state, nxt;
  logic int_cs_s, ext_cs_s, int_cs_d, ext_cs_d;
  logic gate_q, sel_q, ext_req, guard_done, det_clr, blk_inc, tmo;
  logic [DW-1:0] dcnt;
  logic [GW-1:0] gcnt;
  logic [7:0] blk;
  spi_sync #(.N(SYNC_STAGES)) u_int_sync (.clk(clk32), .rst(por), .d(bus.int_csn), .q(int_cs_s));
  spi_sync #(.N(SYNC_STAGES)) u_ext_sync (.clk(clk32), .rst(por), .d(bus.ext_csn), .q(ext_cs_s));
  assign guard_done = gcnt == GW'(GUARD_CYCLES - 1);
  assign det_clr = state == ST_GAP_INT && nxt == ST_INT;
  assign blk_inc = (state == ST_INT && ext_cs_d && !ext_cs_s) ||
                   ((state == ST_EXT || state == ST_GAP_EXT) && int_cs_d && !int_cs_s);
`ifdef MCU_ARB_TIMEOUT_EN
  logic [23:0] tcnt;
  always_ff @(posedge clk32 or posedge por)
    if (por) tcnt <= '0;
    else tcnt <= (state != ST_EXT || !ext_cs_s) ? '0 : (tcnt == EXT_TIMEOUT) ? tcnt : tcnt + 1'b1;
  assign tmo = tcnt == EXT_TIMEOUT;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      ST_INT:     nxt = ext_req ? ST_SW_EXT : ST_INT;
      ST_SW_EXT:  nxt = int_cs_s ? ST_GAP_EXT : ST_SW_EXT;
      ST_GAP_EXT: nxt = (guard_done && ext_cs_s) ? ST_EXT : ST_GAP_EXT;
      ST_EXT:     nxt = (tmo && int_cs_s) ? ST_GAP_INT : ST_EXT;
      ST_GAP_INT: nxt = guard_done ? ST_INT : ST_GAP_INT;
      default:    nxt = ST_INT;
    endcase
  end
  always_ff @(posedge clk32 or posedge por)
    if (por) begin
      state <= ST_INT;
      gate_q <= 1'b1;
      sel_q <= 1'b0;
      gcnt <= '0;
      dcnt <= '0;
      ext_req <= 1'b0;
      int_cs_d <= 1'b1;
      ext_cs_d <= 1'b1;
      blk <= '0;
    end else begin
      state <= nxt;
      gate_q <= nxt == ST_GAP_EXT || nxt == ST_GAP_INT;
      sel_q <= nxt == ST_EXT || nxt == ST_GAP_INT;
      gcnt <= (nxt != state) ? '0 : guard_done ? gcnt : gcnt + 1'b1;
      dcnt <= (ext_cs_s || det_clr) ? '0 : (dcnt == DW'(DET_CYCLES)) ? dcnt : dcnt + 1'b1;
      ext_req <= det_clr ? 1'b0 : ext_req | (!ext_cs_s && dcnt == DW'(DET_CYCLES - 1));
      int_cs_d <= int_cs_s;
      ext_cs_d <= ext_cs_s;
      blk <= blk + 8'(blk_inc && blk != 8'hFF);
    end
  assign bus.mcu_csn = gate_q | (sel_q ? bus.ext_csn : bus.int_csn);
  assign bus.mcu_sclk = !gate_q & (sel_q ? bus.ext_sclk : bus.int_sclk);
  assign bus.mcu_mosi = !gate_q & (sel_q ? bus.ext_mosi : bus.int_mosi);
  assign bus.sel_ext = sel_q;
  assign bus.switching = state == ST_SW_EXT || state == ST_GAP_EXT || state == ST_GAP_INT;
  assign bus.blocked_cnt = blk;
endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// tb_mcu_spi_arbiter: random SPI traffic from both masters checked against a cycle-level port-ownership model
module tb_mcu_spi_arbiter;
  import mcu_arb_pkg::*;
  localparam int S = SYNC_STAGES_D, DET = DET_CYCLES_D, GUARD = GUARD_CYCLES_D;
  localparam int P_INT = 0, P_WAIT = 1, P_GAP = 2, P_EXT = 3;
  logic clk32 = 0, por = 0;
  int total = 0, bad = 0;
  bit sw_seen;
  mcu_spi_arbiter_if bus();
  mcu_spi_arbiter dut (.clk32(clk32), .por(por), .bus(bus));
  always #5 clk32 = ~clk32;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  int ph, age, run, blk;
  bit req, fresh, pis, pes;
  bit ih[S], eh[S];
  // model: who owns the port, whether a handover is pending, and how long the guard gap has lasted
  always @(posedge clk32 or posedge por) begin
    if (por) begin
      ph = P_INT; age = 0; run = 0; blk = 0; req = 0; fresh = 1; pis = 1; pes = 1;
      for (int i = 0; i < S; i++) begin ih[i] = 1; eh[i] = 1; end
    end else begin
      bit ci, ce;
      ci = ih[S-1]; ce = eh[S-1];
      if (((ph == P_INT && pes && !ce) || ((ph == P_EXT || ph == P_GAP) && pis && !ci)) && blk < 255) blk++;
      case (ph)
        P_INT: if (req) ph = P_WAIT;
        P_WAIT: if (ci) begin ph = P_GAP; age = 0; end
        P_GAP: begin age++; if (age >= GUARD && ce) ph = P_EXT; end
        default: ;
      endcase
      run = ce ? 0 : run + 1;
      if (run >= DET) req = 1;
      pis = ci; pes = ce; fresh = 0;
      for (int i = S - 1; i > 0; i--) begin ih[i] = ih[i-1]; eh[i] = eh[i-1]; end
      ih[0] = bus.int_csn; eh[0] = bus.ext_csn;
    end
  end
  function automatic logic [12:0] exp_outs();
    bit g, x;
    g = fresh || ph == P_GAP;
    x = ph == P_EXT;
    return {g ? 1'b0 : (x ? bus.ext_sclk : bus.int_sclk), g ? 1'b1 : (x ? bus.ext_csn : bus.int_csn),
            g ? 1'b0 : (x ? bus.ext_mosi : bus.int_mosi), x, ph == P_WAIT || ph == P_GAP, 8'(blk)};
  endfunction
  always @(negedge clk32) begin
    chk("outs", 32'({bus.mcu_sclk, bus.mcu_csn, bus.mcu_mosi, bus.sel_ext, bus.switching, bus.blocked_cnt}),
        32'(exp_outs()));
    if (bus.switching) sw_seen = 1;
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk32); #1; end
  endtask
  task automatic pins(bit x, bit csn, bit sclk, bit mosi);
    if (x) {bus.ext_csn, bus.ext_sclk, bus.ext_mosi} = {csn, sclk, mosi};
    else {bus.int_csn, bus.int_sclk, bus.int_mosi} = {csn, sclk, mosi};
  endtask
  task automatic frame(bit x, int bits);
    pins(x, 0, 0, 0); tick();
    repeat (bits) begin
      pins(x, 0, 1, 1'($urandom)); tick();
      pins(x, 0, 0, 1'($urandom)); tick();
    end
    pins(x, 1, 0, 0); tick();
  endtask
  task automatic reset_pulse();
    pins(0, 1, 0, 0); pins(1, 1, 0, 0);
    por = 1; tick(2); por = 0; tick();
  endtask
  initial begin
    pins(0, 1, 0, 0); pins(1, 1, 0, 0);
    #1 por = 1; tick(2); por = 0;
    tick(3); frame(0, 8); tick(2);
    chk("s1_sel", 32'(bus.sel_ext), 0);
    chk("s1_blk", 32'(bus.blocked_cnt), 0);
    bus.ext_csn = 0; tick(10); bus.ext_csn = 1; tick(20);
    chk("s2_sel", 32'(bus.sel_ext), 0);
    chk("s2_sw", 32'(bus.switching), 0);
    sw_seen = 0;
    fork
      frame(0, 16);
      begin tick(5); bus.ext_csn = 0; tick(20); bus.ext_csn = 1; end
    join
    begin
      int n = 0;
      while (!bus.sel_ext && n < 200) begin tick(); n++; end
    end
    chk("s3_sel", 32'(bus.sel_ext), 1);
    chk("s3_sw_seen", 32'(sw_seen), 1);
    tick(2);
    chk("s3_sw_done", 32'(bus.switching), 0);
    repeat (300)
      fork
        frame(0, $urandom_range(1, 2));
        if ($urandom_range(0, 3) == 0) frame(1, 3);
      join
    tick(4);
    chk("s4_blk", 32'(bus.blocked_cnt), 255);
    chk("s4_sel", 32'(bus.sel_ext), 1);
    reset_pulse();
    bus.ext_csn = 0;
    begin
      int n = 0;
      while (ph != P_GAP && n < 100) begin tick(); n++; end
    end
    chk("s5_in_gap", 32'(bus.switching), 1);
    #2 por = 1;
    #1 chk("s5_csn", 32'(bus.mcu_csn), 1);
    chk("s5_sel", 32'(bus.sel_ext), 0);
    chk("s5_blk", 32'(bus.blocked_cnt), 0);
    bus.ext_csn = 1; tick(); por = 0; tick(5);
    chk("s5_sel_after", 32'(bus.sel_ext), 0);
    chk("s5_sw_after", 32'(bus.switching), 0);
    repeat (6) begin
      reset_pulse();
      fork
        repeat (15) begin tick($urandom_range(0, 6)); frame(0, $urandom_range(1, 6)); end
        repeat (10) begin
          tick($urandom_range(0, 10));
          case ($urandom_range(0, 2))
            0: begin bus.ext_csn = 0; tick($urandom_range(1, DET - 2)); bus.ext_csn = 1; tick(); end
            1: frame(1, $urandom_range(8, 12));
            default: tick(3);
          endcase
        end
      join
      tick(40);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mcu_spi_arbiter.md
Name: mcu_spi_arbiter

Overview:
- Shares the single MCU SPI slave port between two masters: the on-board BL616 (internal) and an optional external M0S Dock.
- Selects one master and muxes its sclk, csn and mosi onto the MCU port.
- Switches masters only at frame boundaries, with a forced-idle guard gap between them, so the downstream SPI slave never sees a spliced frame.
- Sits between the board pins and the core MCU interface. Replaces the plain sticky select latch.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for the csn inputs.
- DET_CYCLES, 16: number of consecutive synced-low ext_csn cycles that count as an external request (rejects a floating or unconnected pin).
- GUARD_CYCLES, 4: cycles mcu_csn is forced high during a switch.
- EXT_TIMEOUT, 24'hFFFFFF: external idle cycles before reverting to internal (used only with the optional feature).

Ports:
- clk32  in  1  32 MHz system clock
- por  in  1  asynchronous, active-high reset
- int_sclk  in  1  BL616 SPI clock (raw pin)
- int_csn  in  1  BL616 chip select, active low (raw pin)
- int_mosi  in  1  BL616 data to FPGA
- ext_sclk  in  1  M0S SPI clock (raw pin)
- ext_csn  in  1  M0S chip select, active low (raw pin)
- ext_mosi  in  1  M0S data to FPGA
- mcu_sclk  out  1  muxed SPI clock to core
- mcu_csn  out  1  muxed chip select to core
- mcu_mosi  out  1  muxed data to core
- sel_ext  out  1  1 = external master owns the port
- switching  out  1  high during any switch or guard state
- blocked_cnt  out  8  frames started by the non-selected master; saturating

Behaviour:
- Only int_csn and ext_csn are synchronized (SYNC_STAGES flops, reset to 1), giving int_cs_s and ext_cs_s.
- sclk and mosi pass combinationally, selected by the registered sel_ext and gate.
- gate = 1 forces mcu_csn = 1, mcu_sclk = 0, mcu_mosi = 0. Otherwise the outputs follow the selected master's raw pins.
- Reset values: state INT, sel_ext = 0, gate = 1 while por is high, switching = 0, blocked_cnt = 0, all counters 0.
- After por falls, gate drops on the first clk32 edge.
- ext_req detector: counts consecutive cycles with ext_cs_s = 0. Sets ext_req when the count reaches DET_CYCLES. Any high cycle clears the count.
- FSM transitions:
  - INT: outputs follow int. On ext_req go to SW_EXT.
  - SW_EXT: outputs still follow int, switching = 1. Go to GAP_EXT on the first cycle with int_cs_s = 1 (one cycle if already idle). An in-progress int frame always completes.
  - GAP_EXT: gate = 1. Guard counter runs 0..GUARD_CYCLES-1. Go to EXT when the guard has expired AND ext_cs_s = 1, so the port starts at a clean ext frame boundary. sel_ext rises on entry to EXT.
  - EXT: outputs follow ext. Without the optional feature, EXT is absorbing until por.
- blocked_cnt increments by 1 on each falling edge of the non-selected master's csn_s while in INT/EXT, and on each int_cs_s falling edge during GAP_EXT. It saturates at 255 and is cleared only by por.
- ext_req arriving in the same cycle as an int_cs_s falling edge: int keeps the port, and the switch waits for that frame to end.
- A glitch on ext_csn shorter than DET_CYCLES causes no state change.
- por asserted mid-frame or mid-switch: all state returns to reset values immediately (asynchronous), and mcu_csn goes high combinationally.

Optional Feature:
- Macro MCU_ARB_TIMEOUT_EN.
- When defined: in EXT, a 24-bit counter increments while ext_cs_s = 1 and clears when it is 0. When the counter reaches EXT_TIMEOUT and int_cs_s = 1, go to GAP_INT.
- GAP_INT: gate = 1 for GUARD_CYCLES, then go to INT. sel_ext falls on entry to INT, and the ext_req detector is cleared. The external dock can re-acquire the port through the normal ext_req path.
- When undefined: no timeout counter and no GAP_INT state; external selection is sticky.

Decomposition:
- Package mcu_arb_pkg holds:
  - the state enum (INT, SW_EXT, GAP_EXT, EXT, GAP_INT);
  - default constants for SYNC_STAGES, DET_CYCLES, GUARD_CYCLES and EXT_TIMEOUT.
- One sub-module, spi_sync: an N-stage reset-to-1 synchronizer, instantiated twice (int_csn, ext_csn).

Test Plan:
- por release with ext_csn held high, int frame of 8 sclk pulses → mcu_* mirror the int pins, sel_ext = 0, blocked_cnt = 0.
- ext_csn low for 10 cycles then high → no switch; sel_ext stays 0.
- Int frame in progress, ext_csn held low 20 cycles then released → int frame completes, then mcu_csn high for ≥4 cycles, then EXT on the first ext_cs_s = 1; sel_ext = 1 and switching pulses.
- In EXT, 300 int_csn frames → blocked_cnt = 255 (saturated); mcu_* never toggle from int pins.
- por pulsed during GAP_EXT → mcu_csn = 1 immediately; after release state = INT, sel_ext = 0.
- With MCU_ARB_TIMEOUT_EN and EXT_TIMEOUT = 100: ext idle 100 cycles → GAP_INT of 4 cycles, then sel_ext = 0. Ext frame at cycle 99 → timer restarts and the port stays ext.
